bin2bcd_seq: RTL and testbench

// - Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that produces the

---
 rtl/bin2bcd_seq_pkg.sv | 12 +
 rtl/bin2bcd_seq_add3_cell.sv | 11 +
 rtl/bin2bcd_seq.sv | 87 ++++++++
 tb/tb_bin2bcd_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared constants for the sequential binary-to-BCD converter
package bin2bcd_seq_pkg;

  // Digit width, shared with the 7-segment decoders
  localparam int BCD_SIZE = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [BCD_SIZE-1:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/bin2bcd_seq_add3_cell.sv
// rtl/bin2bcd_seq_add3_cell.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_add3_cell
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_SIZE-1:0] din,
  output logic [BCD_SIZE-1:0] dout
);

  assign dout = (din >= BCD_SIZE'(5)) ? din + BCD_SIZE'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-clock binary-to-BCD converter with start/busy/done handshake
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [BIN_WIDTH-1:0]         bin_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [BCD_SIZE*DIGITS-1:0]   bcd_o,
  output logic                         overflow_o
);

  localparam int ACC_W = BCD_SIZE * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  logic [0:0]           state;
  logic [BIN_WIDTH-1:0] bin_reg;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_adj;
  logic [ACC_W-1:0]     acc_next;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_acc;
  logic                 ovf_next;
  logic                 last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .din  (acc[g*BCD_SIZE +: BCD_SIZE]),
      .dout (acc_adj[g*BCD_SIZE +: BCD_SIZE])
    );
  end

  // A bit leaving the top digit means the value cannot fit in DIGITS digits
  always_comb begin
    acc_next = {acc_adj[ACC_W-2:0], bin_reg[BIN_WIDTH-1]};
    ovf_next = ovf_acc | acc_adj[ACC_W-1];
    last     = (cnt == CNT_W'(BIN_WIDTH - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bin_reg    <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      bcd_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            bin_reg <= bin_i;
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            busy_o  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          acc     <= acc_next;
          bin_reg <= bin_reg << 1;
          ovf_acc <= ovf_next;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            overflow_o <= ovf_next;
            bcd_o      <= ovf_next ? {DIGITS{BCD_NINE}} : acc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (8-bit and 10-bit instances)
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic        start10 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic [9:0]  bin10 = '0;
  logic        busy8, done8, ovf8;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd8, bcd10;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  // Reference model state: edges remaining until done, captured operand, expected outputs
  int          left8 = 0, left10 = 0;
  int          cap8 = 0, cap10 = 0;
  logic        e_busy8 = 0, e_done8 = 0, e_ovf8 = 0;
  logic        e_busy10 = 0, e_done10 = 0, e_ovf10 = 0;
  logic [11:0] e_bcd8 = 0, e_bcd10 = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .bin_i(bin8),
    .busy_o(busy8), .done_o(done8), .bcd_o(bcd8), .overflow_o(ovf8)
  );

  bin2bcd_seq #(.BIN_WIDTH(10), .DIGITS(3)) dut10 (
    .clk_i(clk), .rst_i(rst), .start_i(start10), .bin_i(bin10),
    .busy_o(busy10), .done_o(done10), .bcd_o(bcd10), .overflow_o(ovf10)
  );

  // {overflow, 3-digit BCD} by plain decimal arithmetic
  function automatic logic [12:0] ref_bcd(input int v);
    if (v > 999) return {1'b1, 12'h999};
    return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [12:0] r;
    if (rst) begin
      left8 = 0; e_busy8 = 0; e_done8 = 0; e_bcd8 = 0; e_ovf8 = 0;
      left10 = 0; e_busy10 = 0; e_done10 = 0; e_bcd10 = 0; e_ovf10 = 0;
    end else begin
      e_done8 = 0;
      if (left8 == 0) begin
        if (start8) begin cap8 = int'(bin8); left8 = 8; e_busy8 = 1; end
      end else begin
        left8--;
        if (left8 == 0) begin
          r = ref_bcd(cap8);
          e_busy8 = 0; e_done8 = 1; e_bcd8 = r[11:0]; e_ovf8 = r[12];
        end
      end
      e_done10 = 0;
      if (left10 == 0) begin
        if (start10) begin cap10 = int'(bin10); left10 = 10; e_busy10 = 1; end
      end else begin
        left10--;
        if (left10 == 0) begin
          r = ref_bcd(cap10);
          e_busy10 = 0; e_done10 = 1; e_bcd10 = r[11:0]; e_ovf10 = r[12];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy8", busy8, e_busy8);
      chk("done8", done8, e_done8);
      chk("bcd8", bcd8, e_bcd8);
      chk("ovf8", ovf8, e_ovf8);
      chk("busy10", busy10, e_busy10);
      chk("done10", done10, e_done10);
      chk("bcd10", bcd10, e_bcd10);
      chk("ovf10", ovf10, e_ovf10);
      for (int i = 0; i < 3; i++) begin
        chk("nibble8_le9", 32'(bcd8[4*i +: 4] <= 4'd9), 1);
        chk("nibble10_le9", 32'(bcd10[4*i +: 4] <= 4'd9), 1);
      end
    end
  end

  // One conversion with a literal expectation, latency and busy-length checks
  task automatic run(input int k, input int v, input logic [11:0] eb, input logic eo, input string tag);
    int w;
    int seen;
    int nb;
    w = (k == 0) ? 8 : 10;
    seen = 0;
    nb = 0;
    @(negedge clk);
    if (k == 0) begin start8 = 1'b1; bin8 = 8'(v); end
    else begin start10 = 1'b1; bin10 = 10'(v); end
    @(negedge clk);
    start8 = 1'b0;
    start10 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) @(negedge clk);
      if ((k == 0) ? done8 : done10) begin seen = i; break; end
      if ((k == 0) ? busy8 : busy10) nb++;
    end
    chk({tag, "_latency"}, seen, w + 1);
    chk({tag, "_busy_cycles"}, nb, w);
    chk({tag, "_bcd"}, (k == 0) ? bcd8 : bcd10, eb);
    chk({tag, "_ovf"}, (k == 0) ? ovf8 : ovf10, eo);
  endtask

  initial begin
    int vals[256];
    int dn;
    logic [12:0] r;

    chk("model_pin_437", ref_bcd(437), {1'b0, 12'h437});
    chk("model_pin_1000", ref_bcd(1000), {1'b1, 12'h999});

    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_bcd8", bcd8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_busy10", busy10, 0);
    chk("rst_bcd10", bcd10, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    run(0, 0, 12'h000, 1'b0, "v0");
    run(0, 255, 12'h255, 1'b0, "v255");
    run(0, 99, 12'h099, 1'b0, "v99");
    run(1, 1023, 12'h999, 1'b1, "v1023");
    run(1, 999, 12'h999, 1'b0, "v999");

    // Start held high while operands keep changing
    @(negedge clk);
    start8 = 1'b1;
    start10 = 1'b1;
    repeat (60) begin
      bin8 = 8'($urandom);
      bin10 = 10'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    start10 = 1'b0;
    repeat (15) @(negedge clk);

    // Reset on the 4th shift edge aborts the conversion silently
    start8 = 1'b1;
    bin8 = 8'd200;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_bcd", bcd8, 0);
    chk("abort_done", done8, 0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("abort_no_done", dn, 0);
    run(0, 200, 12'h200, 1'b0, "after_abort");

    for (int i = 0; i < 256; i++) vals[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = vals[i]; vals[i] = vals[j]; vals[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      r = ref_bcd(vals[i]);
      run(0, vals[i], r[11:0], r[12], "sweep8");
    end

    for (int i = 0; i < 30; i++) begin
      int v;
      v = (i % 3 == 0) ? int'($urandom_range(1023, 990)) : int'($urandom_range(1023, 0));
      r = ref_bcd(v);
      run(1, v, r[11:0], r[12], "rand10");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
